// File: rtl/vga_pixel_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_pixel_out
// Purpose  : Final display stage. Generates VGA raster timing, publishes the
//            raster position to the drawing objects and the priority mux, and
//            realigns the mux's RGB332 pixel with delayed sync/blank flags
//            before expanding it to 4:4:4 for the board DAC.
// Ports    : clk          in   pixel clock
//            reset        in   synchronous reset, active-high
//            RGBIn        in   [7:0] RGB332 pixel {R[7:5],G[4:2],B[1:0]}
//            pixelX       out  [10:0] horizontal count (registered)
//            pixelY       out  [10:0] vertical count (registered)
//            startOfFrame out  high while the counters sit on the last
//                              position of the frame
//            vgaR/G/B     out  [3:0] colour to DAC
//            hSync        out  horizontal sync, active-low
//            vSync        out  vertical sync, active-low
//            blankN       out  1 = visible pixel being driven
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    // Clocks from a pixelX/pixelY update to the matching RGBIn; legal 1..8.
    parameter int PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN
);

    localparam logic [10:0] c_h_max      = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] c_v_max      = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] c_h_act      = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_act      = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_vs_start   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end     = 11'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        w_h_wrap;
    logic        w_v_wrap;

    assign w_h_wrap = (r_h_cnt == c_h_max);
    assign w_v_wrap = (r_v_cnt == c_v_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? 11'd0 : r_v_cnt + 11'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    assign pixelX       = r_h_cnt;
    assign pixelY       = r_v_cnt;
    assign startOfFrame = w_h_wrap && w_v_wrap;

    // ------------------------------------------------------------------
    // Raw timing flags for the position currently on the counters
    // ------------------------------------------------------------------
    logic w_active;
    logic w_hs_n;
    logic w_vs_n;

    assign w_active = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hs_n   = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
    assign w_vs_n   = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));

    // ------------------------------------------------------------------
    // Flag delay line: the last stage lines up with the RGBIn value that
    // the drawers and mux produce for the same position. Reset loads the
    // idle pattern so no sync pulse or visible pixel leaks out while the
    // line refills.
    // ------------------------------------------------------------------
    logic r_act_dly [PIPE_LAT];
    logic r_hs_dly  [PIPE_LAT];
    logic r_vs_dly  [PIPE_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_act_dly[i] <= 1'b0;
                r_hs_dly[i]  <= 1'b1;
                r_vs_dly[i]  <= 1'b1;
            end
        end else begin
            r_act_dly[0] <= w_active;
            r_hs_dly[0]  <= w_hs_n;
            r_vs_dly[0]  <= w_vs_n;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_act_dly[i] <= r_act_dly[i-1];
                r_hs_dly[i]  <= r_hs_dly[i-1];
                r_vs_dly[i]  <= r_vs_dly[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Colour expansion by MSB replication, so full-scale 3/2-bit codes
    // map to full-scale 4-bit codes.
    // ------------------------------------------------------------------
    logic [3:0] w_r4;
    logic [3:0] w_g4;
    logic [3:0] w_b4;

    assign w_r4 = {RGBIn[7:5], RGBIn[7]};
    assign w_g4 = {RGBIn[4:2], RGBIn[4]};
    assign w_b4 = {RGBIn[1:0], RGBIn[1:0]};

    // ------------------------------------------------------------------
    // DAC output register
    // ------------------------------------------------------------------
    logic [3:0] r_vga_r;
    logic [3:0] r_vga_g;
    logic [3:0] r_vga_b;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_blank_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vga_r   <= '0;
            r_vga_g   <= '0;
            r_vga_b   <= '0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            r_vga_r   <= r_act_dly[PIPE_LAT-1] ? w_r4 : 4'd0;
            r_vga_g   <= r_act_dly[PIPE_LAT-1] ? w_g4 : 4'd0;
            r_vga_b   <= r_act_dly[PIPE_LAT-1] ? w_b4 : 4'd0;
            r_hsync   <= r_hs_dly[PIPE_LAT-1];
            r_vsync   <= r_vs_dly[PIPE_LAT-1];
            r_blank_n <= r_act_dly[PIPE_LAT-1];
        end
    end

    assign vgaR   = r_vga_r;
    assign vgaG   = r_vga_g;
    assign vgaB   = r_vga_b;
    assign hSync  = r_hsync;
    assign vSync  = r_vsync;
    assign blankN = r_blank_n;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_out
// Purpose  : Directed self-checking bench for vga_pixel_out. Three instances:
//            full 640x480 timing with PIPE_LAT=2 and PIPE_LAT=1, plus a
//            reduced-raster instance (15x8 totals, PIPE_LAT=3) so whole-frame
//            behaviour fits in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] rgb_a, rgb_b, rgb_c;

    logic [10:0] w_a_px, w_a_py, w_b_px, w_b_py, w_c_px, w_c_py;
    logic        w_a_sof, w_b_sof, w_c_sof;
    logic [3:0]  w_a_r, w_a_g, w_a_b, w_b_r, w_b_g, w_b_b, w_c_r, w_c_g, w_c_b;
    logic        w_a_hs, w_a_vs, w_a_bl, w_b_hs, w_b_vs, w_b_bl, w_c_hs, w_c_vs, w_c_bl;

    vga_pixel_out #(.PIPE_LAT(2)) u_dut_a (
        .clk(clk), .reset(reset), .RGBIn(rgb_a),
        .pixelX(w_a_px), .pixelY(w_a_py), .startOfFrame(w_a_sof),
        .vgaR(w_a_r), .vgaG(w_a_g), .vgaB(w_a_b),
        .hSync(w_a_hs), .vSync(w_a_vs), .blankN(w_a_bl)
    );

    vga_pixel_out #(.PIPE_LAT(1)) u_dut_b (
        .clk(clk), .reset(reset), .RGBIn(rgb_b),
        .pixelX(w_b_px), .pixelY(w_b_py), .startOfFrame(w_b_sof),
        .vgaR(w_b_r), .vgaG(w_b_g), .vgaB(w_b_b),
        .hSync(w_b_hs), .vSync(w_b_vs), .blankN(w_b_bl)
    );

    vga_pixel_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_LAT(3)
    ) u_dut_c (
        .clk(clk), .reset(reset), .RGBIn(rgb_c),
        .pixelX(w_c_px), .pixelY(w_c_py), .startOfFrame(w_c_sof),
        .vgaR(w_c_r), .vgaG(w_c_g), .vgaB(w_c_b),
        .hSync(w_c_hs), .vSync(w_c_vs), .blankN(w_c_bl)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0]  vec_in  [6];
    logic [11:0] vec_exp [6];

    int hs_first, hs_cnt, bl_cnt, bl_first, bl_last, fall1, fall2;
    int pos_err, blank_rgb_err, act_rgb_err, sof_cnt, vs_low, b_hs_first, b_bl_first;
    int a_red, a_red_x, a_red_y, b_red, b_red_x;
    logic [11:0] a_red_val;
    int rst_err_a, rst_err_b, rst_err_c, early_a, early_b, early_c, pos2_err;
    int sof_c_cnt, sof1, sof2, sof_pos_err, c_vs_low, c_vs_first, c_hs_low, c_bl, c_rgb_err;
    logic prev_hs;

    initial begin
        vec_in  = '{8'hFF, 8'hE0, 8'h1C, 8'h03, 8'h92, 8'h6D};
        vec_exp = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'h99A, 12'h665};

        // ---------------- reset state ----------------
        reset = 1'b1;
        rgb_a = 8'hFF; rgb_b = 8'hFF; rgb_c = 8'hFF;
        repeat (4) tick();
        check_val("rst_px",    32'(w_a_px), 0);
        check_val("rst_py",    32'(w_a_py), 0);
        check_val("rst_sof",   32'(w_a_sof), 0);
        check_val("rst_rgb",   32'({w_a_r, w_a_g, w_a_b}), 0);
        check_val("rst_blank", 32'(w_a_bl), 0);
        check_val("rst_hs",    32'(w_a_hs), 1);
        check_val("rst_vs",    32'(w_a_vs), 1);
        check_val("rst_c_bl",  32'(w_c_bl), 0);
        reset = 1'b0;

        // ---------------- lines 0-1: timing, blanking (n=0 is release) ----------------
        hs_first = -1; hs_cnt = 0; bl_cnt = 0; bl_first = -1; bl_last = -1;
        fall1 = -1; fall2 = -1; pos_err = 0; blank_rgb_err = 0; act_rgb_err = 0;
        sof_cnt = 0; vs_low = 0; b_hs_first = -1; b_bl_first = -1; prev_hs = 1'b1;
        for (int n = 0; n < 1600; n++) begin
            if (32'(w_a_px) != 32'(n % 800) || 32'(w_a_py) != 32'(n / 800)) pos_err++;
            if (n < 803) begin
                if (!w_a_hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = n;
                end
                if (w_a_bl) begin
                    bl_cnt++;
                    if (bl_first < 0) bl_first = n;
                    bl_last = n;
                end
            end
            if (prev_hs && !w_a_hs) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            prev_hs = w_a_hs;
            if (!w_a_bl && {w_a_r, w_a_g, w_a_b} != 12'h000) blank_rgb_err++;
            if (w_a_bl && {w_a_r, w_a_g, w_a_b} != 12'hFFF) act_rgb_err++;
            if (w_a_sof) sof_cnt++;
            if (!w_a_vs) vs_low++;
            if (!w_b_hs && b_hs_first < 0) b_hs_first = n;
            if (w_b_bl && b_bl_first < 0) b_bl_first = n;
            tick();
        end
        check_val("pos_track",     32'(pos_err), 0);
        check_val("hs_first",      32'(hs_first), 659);
        check_val("hs_width",      32'(hs_cnt), 96);
        check_val("hs_fall1",      32'(fall1), 659);
        check_val("line_period",   32'(fall2 - fall1), 800);
        check_val("blank_count",   32'(bl_cnt), 640);
        check_val("blank_first",   32'(bl_first), 3);
        check_val("blank_last",    32'(bl_last), 642);
        check_val("blank_rgb_0",   32'(blank_rgb_err), 0);
        check_val("active_rgb",    32'(act_rgb_err), 0);
        check_val("sof_none",      32'(sof_cnt), 0);
        check_val("vs_none",       32'(vs_low), 0);
        check_val("b_hs_first",    32'(b_hs_first), 658);
        check_val("b_blank_first", 32'(b_bl_first), 2);

        // ---------------- line 2: colour expansion ----------------
        rgb_b = 8'h00;
        repeat (20) tick();
        for (int k = 0; k < 6; k++) begin
            rgb_a = vec_in[k];
            tick();
            check_val($sformatf("color_%0h", vec_in[k]), 32'({w_a_r, w_a_g, w_a_b}), 32'(vec_exp[k]));
        end
        check_val("color_blankN", 32'(w_a_bl), 1);
        rgb_a = 8'h00;
        tick();

        // ---------------- line 3: single-pixel latency ----------------
        a_red = 0; a_red_x = -1; a_red_y = -1; b_red = 0; b_red_x = -1; a_red_val = '0;
        for (int g = 0; g < 2000 && w_a_py != 11'd4; g++) begin
            if ({w_a_r, w_a_g, w_a_b} != 12'h000) begin
                a_red++; a_red_x = int'(w_a_px); a_red_y = int'(w_a_py);
                a_red_val = {w_a_r, w_a_g, w_a_b};
            end
            if ({w_b_r, w_b_g, w_b_b} != 12'h000) begin
                b_red++; b_red_x = int'(w_b_px);
            end
            rgb_a = (w_a_px == 11'd102 && w_a_py == 11'd3) ? 8'hE0 : 8'h00;
            rgb_b = (w_b_px == 11'd101 && w_b_py == 11'd3) ? 8'hE0 : 8'h00;
            tick();
        end
        check_val("wait_line4", 32'(w_a_py), 4);
        check_val("lat_a_count", 32'(a_red), 1);
        check_val("lat_a_x",     32'(a_red_x), 103);
        check_val("lat_a_y",     32'(a_red_y), 3);
        check_val("lat_a_val",   32'(a_red_val), 32'h0F00);
        check_val("lat_b_count", 32'(b_red), 1);
        check_val("lat_b_x",     32'(b_red_x), 102);

        // ---------------- mid-line reset at x=300 ----------------
        rgb_a = 8'hFF; rgb_b = 8'hFF; rgb_c = 8'hFF;
        for (int g = 0; g < 1000 && w_a_px != 11'd300; g++) tick();
        check_val("wait_x300", 32'(w_a_px), 300);
        check_val("pre_rst_blank", 32'(w_a_bl), 1);
        reset = 1'b1;
        rst_err_a = 0; rst_err_b = 0;
        repeat (3) begin
            tick();
            if (w_a_px != 0 || w_a_py != 0 || w_a_sof || {w_a_r, w_a_g, w_a_b} != 0 ||
                w_a_bl || !w_a_hs || !w_a_vs) rst_err_a++;
            if (w_b_px != 0 || w_b_py != 0 || w_b_sof || {w_b_r, w_b_g, w_b_b} != 0 ||
                w_b_bl || !w_b_hs || !w_b_vs) rst_err_b++;
        end
        reset = 1'b0;
        check_val("midrst_a", 32'(rst_err_a), 0);
        check_val("midrst_b", 32'(rst_err_b), 0);

        // ---------------- restart + reduced-raster frames ----------------
        early_a = 0; early_b = 0; pos2_err = 0;
        sof_c_cnt = 0; sof1 = -1; sof2 = -1; sof_pos_err = 0;
        c_vs_low = 0; c_vs_first = -1; c_hs_low = 0; c_bl = 0; c_rgb_err = 0;
        for (int n = 0; n < 250; n++) begin
            if (32'(w_a_px) != 32'(n) || w_a_py != 0) pos2_err++;
            if (n < 3 && (!w_a_hs || w_a_bl || {w_a_r, w_a_g, w_a_b} != 0)) early_a++;
            if (n == 3) begin
                check_val("restart_a_blank", 32'(w_a_bl), 1);
                check_val("restart_a_rgb",   32'({w_a_r, w_a_g, w_a_b}), 32'h0FFF);
            end
            if (n < 2 && (!w_b_hs || w_b_bl)) early_b++;
            if (n == 2) check_val("restart_b_blank", 32'(w_b_bl), 1);
            if (w_c_sof) begin
                sof_c_cnt++;
                if (sof1 < 0) sof1 = n; else sof2 = n;
                if (w_c_px != 11'd14 || w_c_py != 11'd7) sof_pos_err++;
            end
            if (n >= 4 && n < 124) begin
                if (!w_c_vs) begin
                    c_vs_low++;
                    if (c_vs_first < 0) c_vs_first = n;
                end
                if (!w_c_hs) c_hs_low++;
                if (w_c_bl) c_bl++;
            end
            if (!w_c_bl && {w_c_r, w_c_g, w_c_b} != 0) c_rgb_err++;
            tick();
        end
        check_val("restart_pos",   32'(pos2_err), 0);
        check_val("restart_a_idle", 32'(early_a), 0);
        check_val("restart_b_idle", 32'(early_b), 0);
        check_val("c_sof_count",   32'(sof_c_cnt), 2);
        check_val("c_sof_first",   32'(sof1), 119);
        check_val("c_sof_period",  32'(sof2 - sof1), 120);
        check_val("c_sof_pos",     32'(sof_pos_err), 0);
        check_val("c_vs_width",    32'(c_vs_low), 30);
        check_val("c_vs_first",    32'(c_vs_first), 79);
        check_val("c_hs_frame",    32'(c_hs_low), 24);
        check_val("c_blank_frame", 32'(c_bl), 32);
        check_val("c_blank_rgb_0", 32'(c_rgb_err), 0);

        // ---------------- reduced raster: reset inside hsync/vsync ----------------
        for (int g = 0; g < 300 && !(w_c_px == 11'd11 && w_c_py == 11'd5); g++) tick();
        check_val("wait_c_11_5", 32'({w_c_py, w_c_px}), 32'({11'd5, 11'd11}));
        check_val("c_pre_vs", 32'(w_c_vs), 0);
        reset = 1'b1;
        rst_err_c = 0;
        repeat (3) begin
            tick();
            if (w_c_px != 0 || w_c_py != 0 || w_c_sof || {w_c_r, w_c_g, w_c_b} != 0 ||
                w_c_bl || !w_c_hs || !w_c_vs) rst_err_c++;
        end
        reset = 1'b0;
        check_val("midrst_c", 32'(rst_err_c), 0);
        early_c = 0;
        for (int n = 0; n < 5; n++) begin
            if (n < 4 && (!w_c_hs || !w_c_vs || w_c_bl)) early_c++;
            if (n == 4) begin
                check_val("restart_c_blank", 32'(w_c_bl), 1);
                check_val("restart_c_rgb",   32'({w_c_r, w_c_g, w_c_b}), 32'h0FFF);
            end
            tick();
        end
        check_val("restart_c_idle", 32'(early_c), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
